// File: rtl/narma_pkg.sv
// narma_pkg: Q6.10 format constants, default NARMA-10 coefficients,
// controller state encoding and the saturation helper shared by the datapath.
package narma_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 10;

  localparam int DEF_ORDER  = 10;
  localparam int DEF_COEF_A = 307;   // 0.3  in Q.10
  localparam int DEF_COEF_B = 51;    // 0.05 in Q.10
  localparam int DEF_COEF_C = 1536;  // 1.5  in Q.10
  localparam int DEF_COEF_D = 102;   // 0.1  in Q.10

  typedef enum logic [1:0] {IDLE, SUM, MUL, OUT} state_t;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_t;

  // Clamp a 32-bit unsigned intermediate to width bits and report overflow
  function automatic sat_t satClamp(input logic [31:0] val, input int unsigned width);
    sat_t        res;
    logic [31:0] maxVal;
    maxVal  = (32'd1 << width) - 32'd1;
    res.ovf = (val > maxVal);
    res.val = res.ovf ? maxVal : val;
    return res;
  endfunction

endpackage

// File: rtl/narma_step_controller_if.sv
// narma_step_controller_if: input-sample and output-result valid/ready channels.
interface narma_step_controller_if
  import narma_pkg::*;
#(
  parameter int W = Q_W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] u_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_out;

  modport master (
    output in_valid, u_in, out_ready,
    input  in_ready, out_valid, y_out
  );

  modport slave (
    input  in_valid, u_in, out_ready,
    output in_ready, out_valid, y_out
  );

endinterface

// File: rtl/narma_history_buffer.sv
// narma_history_buffer: circular sample history. Reads are addressed relative
// to the write pointer: offset 0 is the slot about to be overwritten, offset 1
// is the oldest entry of the ORDER-1 window and offset DEPTH-1 is the newest.
module narma_history_buffer
  import narma_pkg::*;
#(
  parameter int DEPTH = DEF_ORDER,
  parameter int W     = Q_W,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          wrEn_i,
  input  logic [PW-1:0] wrPtr_i,
  input  logic [W-1:0]  wrData_i,
  input  logic [PW-1:0] rdOffset_i,
  output logic [W-1:0]  rdData_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  rdSum;
  logic [PW-1:0] rdAddr;

  // Pointer-relative read address, wrapped modulo DEPTH
  always_comb begin
    rdSum = {1'b0, wrPtr_i} + {1'b0, rdOffset_i};
    if (rdSum >= (PW+1)'(DEPTH)) begin
      rdSum = rdSum - (PW+1)'(DEPTH);
    end
    rdAddr = rdSum[PW-1:0];
  end

  assign rdData_o = mem_q[rdAddr];

  // Storage: async reset and sync clear zero every slot, otherwise write at pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wrEn_i) begin
      mem_q[wrPtr_i] <= wrData_i;
    end
  end

endmodule

// File: rtl/narma_step_controller.sv
// narma_step_controller: one NARMA-10 step per accepted sample, computed with
// a history sweep (SUM) and a shared-multiplier sequence (MUL), then held in OUT.
module narma_step_controller
  import narma_pkg::*;
#(
  parameter int ORDER  = DEF_ORDER,
  parameter int W      = Q_W,
  parameter int FRAC   = Q_FRAC,
  parameter int COEF_A = DEF_COEF_A,
  parameter int COEF_B = DEF_COEF_B,
  parameter int COEF_C = DEF_COEF_C,
  parameter int COEF_D = DEF_COEF_D
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  narma_step_controller_if.slave    bus,
  output logic                      busy,
  output logic [15:0]               sample_count,
  output logic                      sat_flag
);

  localparam int PW     = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int AW     = W + PW;
  localparam int PROD_W = W + AW;

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx_q;
  logic [2:0]    step_q;
  logic [AW-1:0] acc_q;
  logic [W-1:0]  yCur_q, uCur_q, uOld_q;
  logic [W-1:0]  t1_q, p_q, t2_q, q_q, t3_q;
  logic          satStep_q;
  logic [W-1:0]  yOut_q;
  logic          outValid_q, inReady_q, busy_q, satFlag_q;
  logic [15:0]   count_q;

  logic [W-1:0]      yRdData, uRdData;
  logic              histWr, histClr;
  logic [W-1:0]      mulA;
  logic [AW-1:0]     mulB;
  logic [PROD_W-1:0] product;
  logic [31:0]       rawSum;
  sat_t              mulSat, addSat;

  assign histWr  = (state_q == OUT) && bus.out_ready;
  assign histClr = (state_q == IDLE) && clear;

  narma_history_buffer #(.DEPTH(ORDER), .W(W), .PW(PW)) yHist (
    .clk(clk), .reset(reset), .clear_i(histClr), .wrEn_i(histWr),
    .wrPtr_i(ptr_q), .wrData_i(yOut_q), .rdOffset_i(idx_q), .rdData_o(yRdData)
  );

  narma_history_buffer #(.DEPTH(ORDER), .W(W), .PW(PW)) uHist (
    .clk(clk), .reset(reset), .clear_i(histClr), .wrEn_i(histWr),
    .wrPtr_i(ptr_q), .wrData_i(uCur_q), .rdOffset_i(PW'(1)), .rdData_o(uRdData)
  );

  // Shared multiplier operand select per MUL step, plus the final add and clamp
  always_comb begin
    mulA = '0;
    mulB = '0;
    case (step_q)
      3'd0: begin mulA = W'(COEF_A); mulB = AW'(yCur_q); end
      3'd1: begin mulA = yCur_q;     mulB = acc_q;        end
      3'd2: begin mulA = W'(COEF_B); mulB = AW'(p_q);    end
      3'd3: begin mulA = uCur_q;     mulB = AW'(uOld_q); end
      3'd4: begin mulA = W'(COEF_C); mulB = AW'(q_q);    end
      default: ;
    endcase
    product = PROD_W'(mulA) * PROD_W'(mulB);
    mulSat  = satClamp(32'(product >> FRAC), W);
    rawSum  = 32'(t1_q) + 32'(t2_q) + 32'(t3_q) + 32'(COEF_D);
    addSat  = satClamp(rawSum, W);
  end

  // Controller FSM: accept, sweep history, multiply sequence (final add in the
  // cycle after t3 lands), then hold the result until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      yCur_q     <= '0;
      uCur_q     <= '0;
      uOld_q     <= '0;
      t1_q       <= '0;
      p_q        <= '0;
      t2_q       <= '0;
      q_q        <= '0;
      t3_q       <= '0;
      satStep_q  <= 1'b0;
      yOut_q     <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
      busy_q     <= 1'b0;
      satFlag_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            ptr_q     <= '0;
            count_q   <= '0;
            satFlag_q <= 1'b0;
          end else if (bus.in_valid) begin
            uCur_q    <= bus.u_in;
            acc_q     <= '0;
            idx_q     <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SUM;
          end
        end
        SUM: begin
          acc_q <= acc_q + AW'(yRdData);
          if (idx_q == '0) uOld_q <= uRdData;
          if (idx_q == PW'(ORDER-1)) begin
            yCur_q    <= yRdData;
            idx_q     <= '0;
            step_q    <= '0;
            satStep_q <= 1'b0;
            state_q   <= MUL;
          end else begin
            idx_q <= idx_q + PW'(1);
          end
        end
        MUL: begin
          case (step_q)
            3'd0: t1_q <= mulSat.val[W-1:0];
            3'd1: p_q  <= mulSat.val[W-1:0];
            3'd2: t2_q <= mulSat.val[W-1:0];
            3'd3: q_q  <= mulSat.val[W-1:0];
            3'd4: t3_q <= mulSat.val[W-1:0];
            default: ;
          endcase
          if (step_q == 3'd5) begin
            yOut_q     <= (satStep_q || addSat.ovf) ? '1 : addSat.val[W-1:0];
            if (satStep_q || addSat.ovf) satFlag_q <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= OUT;
          end else begin
            satStep_q <= satStep_q | mulSat.ovf;
            step_q    <= step_q + 3'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            count_q    <= count_q + 16'd1;
            ptr_q      <= (ptr_q == PW'(ORDER-1)) ? '0 : ptr_q + PW'(1);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.y_out     = yOut_q;
  assign busy          = busy_q;
  assign sample_count  = count_q;
  assign sat_flag      = satFlag_q;

endmodule

// File: tb/tb_narma_step_controller.sv
// tb_narma_step_controller: directed steps with a time-indexed Q.10 truncating
// reference model; expected results are queued on input and popped on output.
module tb_narma_step_controller;
  import narma_pkg::*;

  localparam int ORDER = 10;
  localparam int LAT   = ORDER + 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        busy;
  logic [15:0] sample_count;
  logic        sat_flag;

  narma_step_controller_if #(.W(16)) bus ();

  narma_step_controller #(.ORDER(ORDER)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus),
    .busy(busy), .sample_count(sample_count), .sat_flag(sat_flag)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count rising edges so latency can be measured in cycles
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int     checks = 0;
  int     failures = 0;
  longint yHist [0:63];
  longint uHist [0:63];
  int     stepN;
  bit     modelSat;
  int     modelCount;
  int     expQ [$];
  int     acceptCycle;
  int     lastExp;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      yHist[i] = 0;
      uHist[i] = 0;
    end
    stepN = 0;
    modelSat = 1'b0;
    modelCount = 0;
  endtask

  task automatic modelStep(input longint u, output int res);
    longint y, s, uo, t1, p, t2, q, t3, r;
    bit sat;
    int n;
    n = stepN;
    uHist[n] = u;
    y = yHist[n];
    s = 0;
    for (int i = 0; i < ORDER; i++) if (n - i >= 0) s += yHist[n - i];
    uo = (n - ORDER + 1 >= 0) ? uHist[n - ORDER + 1] : 0;
    sat = 1'b0;
    t1 = (longint'(DEF_COEF_A) * y) >> 10;
    if (t1 > 65535) begin sat = 1'b1; t1 = 65535; end
    p = (y * s) >> 10;
    if (p > 65535) begin sat = 1'b1; p = 65535; end
    t2 = (longint'(DEF_COEF_B) * p) >> 10;
    if (t2 > 65535) begin sat = 1'b1; t2 = 65535; end
    q = (u * uo) >> 10;
    if (q > 65535) begin sat = 1'b1; q = 65535; end
    t3 = (longint'(DEF_COEF_C) * q) >> 10;
    if (t3 > 65535) begin sat = 1'b1; t3 = 65535; end
    r = t1 + t2 + t3 + longint'(DEF_COEF_D);
    if (r > 65535) sat = 1'b1;
    res = sat ? 65535 : int'(r);
    if (sat) modelSat = 1'b1;
    yHist[n + 1] = res;
    stepN++;
  endtask

  // Wait for in_ready, present one sample and queue its expected result
  task automatic applyStimulus(input int u);
    int waitCnt = 0;
    int res;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkVal("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.u_in = u[15:0];
    @(posedge clk);
    #1;
    acceptCycle = cycleCnt;
    bus.in_valid = 1'b0;
    modelStep(u, res);
    expQ.push_back(res);
    checkVal("busy_after_accept", busy, 1);
    checkVal("in_ready_after_accept", bus.in_ready, 0);
  endtask

  // Wait for out_valid, compare against the scoreboard, complete handshake if ready
  task automatic checkOutput(input string tag);
    int waitCnt = 0;
    int exp;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkVal({tag, "_valid"}, bus.out_valid, 1);
    checkVal({tag, "_latency"}, cycleCnt - acceptCycle, LAT);
    exp = (expQ.size() > 0) ? expQ.pop_front() : -1;
    lastExp = exp;
    checkVal(tag, bus.y_out, exp);
    checkVal({tag, "_sat"}, sat_flag, modelSat);
    if (bus.out_ready === 1'b1) begin
      @(posedge clk);
      #1;
      modelCount++;
      checkVal({tag, "_count"}, sample_count, modelCount);
      checkVal({tag, "_valid_drop"}, bus.out_valid, 0);
    end
  endtask

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.u_in = '0;
    bus.out_ready = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_in_ready", bus.in_ready, 1);
    checkVal("rst_out_valid", bus.out_valid, 0);
    checkVal("rst_y_out", bus.y_out, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_count", sample_count, 0);
    checkVal("rst_sat", sat_flag, 0);
    reset = 1'b0;

    $display("[TB] first steps and pointer wrap with u=0.5");
    applyStimulus(512);
    checkOutput("step0");
    applyStimulus(512);
    checkOutput("step1");
    for (int i = 2; i < 12; i++) begin
      applyStimulus(512);
      checkOutput("stepN");
    end

    $display("[TB] output backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(700);
    checkOutput("bp_step");
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = c[0];
      bus.u_in = 16'h1234;
      @(negedge clk);
      checkVal("bp_valid_hold", bus.out_valid, 1);
      checkVal("bp_y_hold", bus.y_out, lastExp);
      checkVal("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    modelCount++;
    checkVal("bp_count", sample_count, modelCount);
    checkVal("bp_valid_drop", bus.out_valid, 0);
    checkVal("bp_busy_drop", busy, 0);

    $display("[TB] saturation with full-scale input");
    for (int i = 0; i < ORDER; i++) begin
      applyStimulus(16'hFFFF);
      checkOutput("sat_step");
    end
    checkVal("sat_last_y", bus.y_out, 16'hFFFF);
    checkVal("sat_flag_sticky", sat_flag, 1);

    $display("[TB] clear in IDLE");
    @(negedge clk);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.u_in = 16'd512;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    checkVal("clr_not_accepted", busy, 0);
    checkVal("clr_in_ready", bus.in_ready, 1);
    checkVal("clr_count", sample_count, 0);
    checkVal("clr_sat", sat_flag, 0);
    modelReset();
    applyStimulus(512);
    checkOutput("clr_first");

    $display("[TB] clear during SUM is ignored");
    applyStimulus(512);
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_sum");

    $display("[TB] reset during MUL");
    applyStimulus(512);
    repeat (12) @(negedge clk);
    checkVal("mul_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkVal("mrst_in_ready", bus.in_ready, 1);
    checkVal("mrst_out_valid", bus.out_valid, 0);
    checkVal("mrst_y_out", bus.y_out, 0);
    checkVal("mrst_busy", busy, 0);
    checkVal("mrst_count", sample_count, 0);
    checkVal("mrst_sat", sat_flag, 0);
    expQ.delete();
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(512);
    checkOutput("mrst_first");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
